exc_fetch_tracker: RTL and testbench

- Fetch-stage exception tracker for the pipelined MIPS core; sits on the F→D boundary.
- Checks each fetch PC against alignment and a parametrised set of legal instruction regions.
- Flags branch-delay-slot status from the instruction currently in D.
- Registers exception info into D and holds it in a trap state until CP0 acknowledges, suppressing further fetch meanwhile.

---
 rtl/exc_fetch_tracker_pkg.sv | 24 ++
 rtl/exc_fetch_tracker_region_check.sv | 24 ++
 rtl/exc_fetch_tracker.sv | 70 +++++++
 tb/tb_exc_fetch_tracker.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/exc_fetch_tracker_pkg.sv
// exc_fetch_tracker_pkg: shared opcodes, exception codes and tracker state encoding
package exc_fetch_tracker_pkg;
  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_REGIMM  = 6'b000001;
  localparam logic [5:0] OP_J       = 6'b000010;
  localparam logic [5:0] OP_JAL     = 6'b000011;
  localparam logic [5:0] OP_BEQ     = 6'b000100;
  localparam logic [5:0] OP_BNE     = 6'b000101;
  localparam logic [5:0] OP_BLEZ    = 6'b000110;
  localparam logic [5:0] OP_BGTZ    = 6'b000111;
  localparam logic [5:0] FN_JR      = 6'b001000;
  localparam logic [5:0] FN_JALR    = 6'b001001;
  localparam logic [4:0] EXC_ADEL   = 5'd4;
  typedef enum logic {RUN = 1'b0, TRAP = 1'b1} state_t;
  function automatic logic is_branch(input logic [31:0] instr);
    logic [5:0] op;
    logic [5:0] fn;
    op = instr[31:26];
    fn = instr[5:0];
    return op == OP_BEQ || op == OP_BNE || op == OP_BLEZ || op == OP_BGTZ ||
           op == OP_REGIMM || op == OP_J || op == OP_JAL ||
           (op == OP_SPECIAL && (fn == FN_JR || fn == FN_JALR));
  endfunction
endpackage

// File: rtl/exc_fetch_tracker_region_check.sv
// addr_region_check: flags an address that is misaligned or outside every legal region
module addr_region_check #(
  parameter int ADDR_W = 32,
  parameter int NUM_REGIONS = 2,
  parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_BASE = {32'h0000_4180, 32'h0000_3000},
  parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_LIMIT = {32'h0000_4ffc, 32'h0000_4ffc},
  parameter int ALIGN_BITS = 2
) (
  input  logic [ADDR_W-1:0] addr,
  output logic              fault
);
  logic [NUM_REGIONS-1:0] hit;
  logic                   misaligned;
  for (genvar i = 0; i < NUM_REGIONS; i++) begin : g_region
    assign hit[i] = addr >= REGION_BASE[i*ADDR_W +: ADDR_W] &&
                    addr <= REGION_LIMIT[i*ADDR_W +: ADDR_W];
  end
  if (ALIGN_BITS > 0) begin : g_align
    assign misaligned = |addr[ALIGN_BITS-1:0];
  end else begin : g_no_align
    assign misaligned = 1'b0;
  end
  assign fault = misaligned || !(|hit);
endmodule

// File: rtl/exc_fetch_tracker.sv
// exc_fetch_tracker: fetch-stage AdEL / delay-slot tracker on the F->D boundary with trap hold
module exc_fetch_tracker
  import exc_fetch_tracker_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int NUM_REGIONS = 2,
  parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_BASE = {32'h0000_4180, 32'h0000_3000},
  parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_LIMIT = {32'h0000_4ffc, 32'h0000_4ffc},
  parameter int ALIGN_BITS = 2,
  parameter int EXC_W = 5,
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic [ADDR_W-1:0] pc_f,
  input  logic [31:0]       instr_d,
  input  logic              ack,
  output logic [ADDR_W-1:0] pc_d,
  output logic              bd_d,
  output logic [EXC_W-1:0]  exccode_d,
  output logic              exc_valid_d,
  output logic              fetch_block,
  output logic [CNT_W-1:0]  exc_count
);
  state_t            state, state_n;
  logic              fault, bd_f, take_ack, clear, capture;
  logic [EXC_W-1:0]  exc_f, code_n;
  logic [ADDR_W-1:0] pc_n;
  logic              bd_n;
  logic [CNT_W-1:0]  cnt_n;
  addr_region_check #(
    .ADDR_W(ADDR_W), .NUM_REGIONS(NUM_REGIONS), .REGION_BASE(REGION_BASE),
    .REGION_LIMIT(REGION_LIMIT), .ALIGN_BITS(ALIGN_BITS)
  ) u_check (
    .addr(pc_f),
    .fault(fault)
  );
  assign exc_f = fault ? EXC_W'(EXC_ADEL) : '0;
  assign bd_f = is_branch(instr_d);
  // ack only counts when a trap is pending; it wins alongside a flush
  assign take_ack = ack && state == TRAP;
  assign clear = flush || take_ack;
  assign capture = state == RUN && !stall && !clear;
  always_comb begin
    state_n = clear ? RUN : (capture && exc_f != '0) ? TRAP : state;
    pc_n = clear ? '0 : capture ? pc_f : pc_d;
    bd_n = clear ? 1'b0 : capture ? bd_f : bd_d;
    code_n = clear ? '0 : capture ? exc_f : exccode_d;
    cnt_n = (take_ack && exc_count != '1) ? exc_count + 1'b1 : exc_count;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
      pc_d <= '0;
      bd_d <= 1'b0;
      exccode_d <= '0;
      exc_count <= '0;
    end else begin
      state <= state_n;
      pc_d <= pc_n;
      bd_d <= bd_n;
      exccode_d <= code_n;
      exc_count <= cnt_n;
    end
  end
  assign exc_valid_d = exccode_d != '0;
  assign fetch_block = state == TRAP;
endmodule

// File: tb/tb_exc_fetch_tracker.sv
// tb_exc_fetch_tracker: table vectors, hand sequences and randomized model check
module tb_exc_fetch_tracker;
  localparam int CNT_W = 2;
  localparam int MAXC = (1 << CNT_W) - 1;
  localparam logic [31:0] NOP = 32'h0000_0000;
  localparam logic [31:0] JAL = 32'h0C00_0040;
  localparam logic [31:0] JALR = 32'h03E0_F809;
  localparam logic [31:0] ADDU = 32'h0043_0821;

  logic clk, reset, stall, flush, ack;
  logic [31:0] pc_f, instr_d, pc_d;
  logic bd_d, exc_valid_d, fetch_block;
  logic [4:0] exccode_d;
  logic [CNT_W-1:0] exc_count;
  int total = 0;
  int bad = 0;

  exc_fetch_tracker #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .pc_f(pc_f),
    .instr_d(instr_d), .ack(ack), .pc_d(pc_d), .bd_d(bd_d), .exccode_d(exccode_d),
    .exc_valid_d(exc_valid_d), .fetch_block(fetch_block), .exc_count(exc_count)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    bit r, s, f, a;
    logic [31:0] pc, ins;
    logic [31:0] e_pc;
    bit e_bd;
    int e_code;
    bit e_blk;
    int e_cnt;
  } vec_t;
  vec_t vq[$];

  // reference model state
  logic [31:0] m_pc;
  bit m_bd, m_trap;
  int m_code, m_cnt;

  function automatic bit legal(input logic [31:0] a);
    logic [31:0] lo[2];
    logic [31:0] hi[2];
    lo = '{32'h3000, 32'h4180};
    hi = '{32'h4ffc, 32'h4ffc};
    if (a % 4 != 0) return 0;
    foreach (lo[k]) if (a >= lo[k] && a <= hi[k]) return 1;
    return 0;
  endfunction

  function automatic bit branchy(input logic [31:0] ins);
    int op, fn;
    op = int'(ins >> 26);
    fn = int'(ins & 32'h3f);
    return (op >= 1 && op <= 7) || (op == 0 && (fn == 8 || fn == 9));
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic apply(input bit r, s, f, a, input logic [31:0] pc, ins);
    reset = r; stall = s; flush = f; ack = a; pc_f = pc; instr_d = ins;
    @(posedge clk);
    #1;
    if (r) begin
      m_pc = 0; m_bd = 0; m_code = 0; m_trap = 0; m_cnt = 0;
    end else if (f || (a && m_trap)) begin
      if (a && m_trap && m_cnt < MAXC) m_cnt++;
      m_pc = 0; m_bd = 0; m_code = 0; m_trap = 0;
    end else if (!m_trap && !s) begin
      m_pc = pc; m_bd = branchy(ins); m_code = legal(pc) ? 0 : 4; m_trap = m_code != 0;
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".pc_d"}, pc_d, m_pc);
    chk({tag, ".bd_d"}, 32'(bd_d), 32'(m_bd));
    chk({tag, ".exccode_d"}, 32'(exccode_d), m_code);
    chk({tag, ".exc_valid_d"}, 32'(exc_valid_d), 32'(m_code != 0));
    chk({tag, ".fetch_block"}, 32'(fetch_block), 32'(m_trap));
    chk({tag, ".exc_count"}, 32'(exc_count), m_cnt);
  endtask

  initial begin
    reset = 1; stall = 0; flush = 0; ack = 0; pc_f = 0; instr_d = 0;
    //             r s f a  pc        instr  e_pc      bd code blk cnt
    vq.push_back('{1,0,0,0, 32'h0,    NOP,  32'h0,    0, 0,  0,  0});
    vq.push_back('{0,0,0,0, 32'h3000, NOP,  32'h3000, 0, 0,  0,  0});
    vq.push_back('{0,0,0,0, 32'h3002, NOP,  32'h3002, 0, 4,  1,  0});
    vq.push_back('{0,0,0,0, 32'h5000, NOP,  32'h3002, 0, 4,  1,  0});
    vq.push_back('{0,1,0,0, 32'h5000, JAL,  32'h3002, 0, 4,  1,  0});
    vq.push_back('{0,0,0,0, 32'h5000, NOP,  32'h3002, 0, 4,  1,  0});
    vq.push_back('{0,0,0,1, 32'h5000, NOP,  32'h0,    0, 0,  0,  1});
    vq.push_back('{0,0,0,0, 32'h5000, NOP,  32'h5000, 0, 4,  1,  1});
    vq.push_back('{0,0,0,1, 32'h3000, NOP,  32'h0,    0, 0,  0,  2});
    vq.push_back('{0,0,0,0, 32'h2ffc, NOP,  32'h2ffc, 0, 4,  1,  2});
    vq.push_back('{0,0,1,0, 32'h3000, NOP,  32'h0,    0, 0,  0,  2});
    vq.push_back('{0,0,0,1, 32'h4ffc, NOP,  32'h4ffc, 0, 0,  0,  2});
    vq.push_back('{0,0,0,0, 32'h3008, JAL,  32'h3008, 1, 0,  0,  2});
    vq.push_back('{0,0,0,0, 32'h300c, JALR, 32'h300c, 1, 0,  0,  2});
    vq.push_back('{0,0,0,0, 32'h3010, ADDU, 32'h3010, 0, 0,  0,  2});
    vq.push_back('{0,1,0,0, 32'h5000, JAL,  32'h3010, 0, 0,  0,  2});
    vq.push_back('{0,0,0,0, 32'h4180, NOP,  32'h4180, 0, 0,  0,  2});
    vq.push_back('{0,0,0,0, 32'h5004, JAL,  32'h5004, 1, 4,  1,  2});
    vq.push_back('{0,0,1,1, 32'h3000, NOP,  32'h0,    0, 0,  0,  3});
    vq.push_back('{0,0,0,0, 32'h3001, NOP,  32'h3001, 0, 4,  1,  3});
    vq.push_back('{0,0,0,1, 32'h3000, NOP,  32'h0,    0, 0,  0,  3});
    vq.push_back('{0,0,0,0, 32'h3003, NOP,  32'h3003, 0, 4,  1,  3});
    vq.push_back('{1,0,0,0, 32'h3004, NOP,  32'h0,    0, 0,  0,  0});
    vq.push_back('{0,0,0,0, 32'h6000, NOP,  32'h6000, 0, 4,  1,  0});
    vq.push_back('{0,1,0,1, 32'h3000, NOP,  32'h0,    0, 0,  0,  1});
    vq.push_back('{0,0,0,0, 32'hfffc, NOP,  32'hfffc, 0, 4,  1,  1});
    foreach (vq[n]) begin
      apply(vq[n].r, vq[n].s, vq[n].f, vq[n].a, vq[n].pc, vq[n].ins);
      chk($sformatf("vec%0d.pc_d", n), pc_d, vq[n].e_pc);
      chk($sformatf("vec%0d.bd_d", n), 32'(bd_d), 32'(vq[n].e_bd));
      chk($sformatf("vec%0d.exccode_d", n), 32'(exccode_d), vq[n].e_code);
      chk($sformatf("vec%0d.exc_valid_d", n), 32'(exc_valid_d), 32'(vq[n].e_code != 0));
      chk($sformatf("vec%0d.fetch_block", n), 32'(fetch_block), 32'(vq[n].e_blk));
      chk($sformatf("vec%0d.exc_count", n), 32'(exc_count), vq[n].e_cnt);
    end
    // saturation: five trap/ack pairs from a fresh reset
    apply(1, 0, 0, 0, 32'h0, NOP);
    for (int k = 0; k < 5; k++) begin
      apply(0, 0, 0, 0, 32'h3002, NOP);
      chk("sat.trap_block", 32'(fetch_block), 32'd1);
      apply(0, 0, 0, 1, 32'h3000, NOP);
    end
    chk("sat.exc_count", 32'(exc_count), 32'd3);
    apply(0, 0, 0, 0, 32'h2000, JAL);
    apply(1, 0, 0, 0, 32'h2000, JAL);
    chk("rst_trap.pc_d", pc_d, 32'h0);
    chk("rst_trap.bd_d", 32'(bd_d), 32'd0);
    chk("rst_trap.exccode_d", 32'(exccode_d), 32'd0);
    chk("rst_trap.fetch_block", 32'(fetch_block), 32'd0);
    chk("rst_trap.exc_count", 32'(exc_count), 32'd0);
    // randomized run against the reference model
    apply(1, 0, 0, 0, 32'h0, NOP);
    for (int k = 0; k < 3000; k++) begin
      logic [31:0] pc, ins;
      pc = 32'h2ff0 + 32'($urandom_range(0, 32'h2020));
      if ($urandom_range(0, 3) != 0) pc = pc & ~32'h3;
      ins = $urandom;
      ins[31:26] = 6'($urandom_range(0, 9));
      if ($urandom_range(0, 1) == 1) ins[5:0] = 6'($urandom_range(7, 10));
      apply($urandom_range(0, 63) == 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 15) == 0, $urandom_range(0, 3) == 0, pc, ins);
      chk_model($sformatf("rnd%0d", k));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
